// File: rtl/mitchell_log_adder.sv
// mitchell_log_adder
//   Two-stage pipelined Mitchell log-domain front end for the 8x8 approximate
//   multiplier. Each unsigned 8-bit operand becomes a 10-bit Mitchell log
//   {k[2:0], m[6:0]}. The two logs are added into an 11-bit log-sum word that
//   feeds mitchell_decoder directly. A valid/ready handshake provides
//   back-pressure, and up to two results can be in flight.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : synchronous active-low reset
//   in_valid   : op_a/op_b valid this cycle
//   in_ready   : operand pair accepted this cycle (when in_valid=1)
//   op_a, op_b : unsigned 8-bit operands
//   out_valid  : log_sum/zero valid
//   out_ready  : downstream accepts the result this cycle
//   log_sum    : {k_a,m_a} + {k_b,m_b}; [10:7] characteristic, [6:0] mantissa
//   zero       : at least one operand was 0 (log_sum forced to 0)
module mitchell_log_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  op_a,
  input  logic [7:0]  op_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [10:0] log_sum,
  output logic        zero
);

  // Mitchell encode: k is the leading-one index. m is the bits below the
  // leading one, left-aligned into 7 bits. x=0 encodes as 0.
  function automatic logic [9:0] mitchell_log(input logic [7:0] x);
    logic [2:0] k;
    logic [7:0] sh;
    k = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (x[i]) k = i[2:0];
    end
    sh = x << (3'd7 - k);
    return {k, sh[6:0]};
  endfunction

  // Full-width log add. A mantissa carry spills into the characteristic,
  // which is the Mitchell approximation of the product's mantissa overflow.
  function automatic logic [10:0] log_add(input logic [9:0] a, input logic [9:0] b,
                                          input logic z);
    logic [10:0] s;
    s = {1'b0, a} + {1'b0, b};
    return z ? 11'd0 : s;
  endfunction

  logic [9:0]  log_a_p1, log_b_p1;
  logic        zero_p1, vld_p1;
  logic [10:0] log_sum_p2;
  logic        zero_p2, vld_p2;
  logic        adv1, adv2;

  assign adv2     = !vld_p2 | out_ready;
  assign adv1     = !vld_p1 | adv2;
  assign in_ready = adv1 & rst_n;

  // ---- p0 -> p1: encode both operands ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      log_a_p1 <= '0;
      log_b_p1 <= '0;
      zero_p1  <= 1'b0;
    end else if (adv1) begin
      vld_p1   <= in_valid & in_ready;
      log_a_p1 <= mitchell_log(op_a);
      log_b_p1 <= mitchell_log(op_b);
      zero_p1  <= (op_a == 8'd0) | (op_b == 8'd0);
    end
  end

  // ---- p1 -> p2: log-domain add ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p2     <= 1'b0;
      log_sum_p2 <= '0;
      zero_p2    <= 1'b0;
    end else if (adv2) begin
      vld_p2     <= vld_p1;
      log_sum_p2 <= log_add(log_a_p1, log_b_p1, zero_p1);
      zero_p2    <= zero_p1;
    end
  end

  assign out_valid = vld_p2;
  assign log_sum   = log_sum_p2;
  assign zero      = zero_p2;

endmodule

// File: tb/tb_mitchell_log_adder.sv
module tb_mitchell_log_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  op_a, op_b;
  logic        out_valid;
  logic        out_ready;
  logic [10:0] log_sum;
  logic        zero;

  mitchell_log_adder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .log_sum   (log_sum),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] v;     // {zero, log_sum}
    int          cyc;
    bit          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  logic [11:0] pend_v;
  bit          pend_lat;
  bit          rand_rdy = 1'b0;
  bit          hold_pend = 1'b0;
  logic [10:0] held_sum;
  logic        held_zero;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference encode written independently of the RTL loop.
  function automatic logic [9:0] ref_log(input logic [7:0] x);
    int k, m;
    if (x == 8'd0) return 10'd0;
    k = 7;
    while (x[k] == 1'b0) k--;
    m = (int'(x) - (1 << k)) << (7 - k);
    return {k[2:0], m[6:0]};
  endfunction

  function automatic logic [11:0] ref_word(input logic [7:0] a, input logic [7:0] b);
    logic [10:0] s;
    if (a == 8'd0 || b == 8'd0) return 12'h800;
    s = {1'b0, ref_log(a)} + {1'b0, ref_log(b)};
    return {1'b0, s};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: transfers seen here take effect at the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
        check_eq("hold_sum", {21'd0, log_sum}, {21'd0, held_sum});
        check_eq("hold_zero", {31'd0, zero}, {31'd0, held_zero});
      end
      hold_pend = out_valid && !out_ready;
      held_sum  = log_sum;
      held_zero = zero;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("result", {20'd0, zero, log_sum}, {20'd0, e.v});
          if (e.lat) check_eq("latency", cyc - e.cyc, 32'd2);
        end
      end
      if (in_valid && in_ready) begin
        exp_t e;
        e.v = pend_v;
        e.cyc = cyc;
        e.lat = pend_lat;
        exp_q.push_back(e);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [11:0] ev,
                      input bit lat);
    bit acc;
    acc      = 1'b0;
    pend_v   = ev;
    pend_lat = lat;
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
      if (acc) break;
    end
    if (!acc) check_eq("accept_timeout", {31'd0, acc}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_eq("drain", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] a, b;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = 8'd0;
    op_b      = 8'd0;
    pend_v    = '0;
    pend_lat  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_log_sum", {21'd0, log_sum}, 32'd0);
    check_eq("rst_zero", {31'd0, zero}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Basic encode-add with latency check
    out_ready = 1'b1;
    send(8'd3, 8'd5, 12'h1E0, 1'b1);
    drain();

    // Extremes streamed back-to-back; latency 2 on each proves 1 per cycle
    send(8'd255, 8'd255, 12'h7FE, 1'b1);
    send(8'd1,   8'd1,   12'h000, 1'b1);
    send(8'd128, 8'd128, 12'h700, 1'b1);
    send(8'd3,   8'd5,   12'h1E0, 1'b1);
    drain();

    // Zero operands
    send(8'd0,  8'd200, 12'h800, 1'b1);
    send(8'd77, 8'd0,   12'h800, 1'b1);
    send(8'd0,  8'd0,   12'h800, 1'b1);
    drain();

    // Back-pressure: two accepts fill the pipe, then in_ready must drop
    out_ready = 1'b0;
    send(8'd10, 8'd20, ref_word(8'd10, 8'd20), 1'b0);
    send(8'd99, 8'd7,  ref_word(8'd99, 8'd7), 1'b0);
    in_valid = 1'b1;
    op_a = 8'd50;
    op_b = 8'd60;
    repeat (3) begin
      @(negedge clk);
      check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(8'd50, 8'd60, ref_word(8'd50, 8'd60), 1'b0);
    send(8'd255, 8'd2, ref_word(8'd255, 8'd2), 1'b0);
    drain();

    // Reset with both stages full
    out_ready = 1'b0;
    send(8'd11, 8'd12, ref_word(8'd11, 8'd12), 1'b0);
    send(8'd13, 8'd14, ref_word(8'd13, 8'd14), 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    check_eq("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mid_rst_log_sum", {21'd0, log_sum}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rel_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    idle(4);
    check_eq("no_stale_out", {31'd0, out_valid}, 32'd0);

    // Random operands with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      case (i % 8)
        0:       a = 8'd0;
        1:       a = 8'd255;
        default: a = 8'($urandom_range(0, 255));
      endcase
      b = 8'($urandom_range(0, 255));
      if (i % 5 == 0) b = 8'(1 << (i % 8));
      send(a, b, ref_word(a, b), 1'b0);
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    rand_rdy = 1'b0;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
